// File: rtl/pr_ex_mem_data_port.sv
// pr_ex_mem_data_port: MEM-stage responder driving a multi-cycle word memory,
// with store lane steering, load extension, misalignment detection and a watchdog.
module pr_ex_mem_data_port #(
    parameter int TIMEOUT = 255,
    parameter int MEM_AW  = 30
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_mem_stage_read,
    input  logic [2:0]        i_mem_stage_write,
    input  logic [31:0]       i_address,
    input  logic [31:0]       i_write_data,
    output logic [31:0]       o_read_data,
    output logic              o_busywait,
    output logic              o_misaligned,
    output logic              o_timeout_err,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [MEM_AW-1:0] o_mem_address,
    output logic [31:0]       o_mem_writedata,
    output logic [3:0]        o_mem_byte_en,
    input  logic [31:0]       i_mem_readdata,
    input  logic              i_mem_busywait
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t r_state, w_next;
    logic [31:0]       r_read_data, r_mem_writedata, r_cnt, w_lane, w_ext, w_wdata;
    logic [MEM_AW-1:0] r_mem_address;
    logic [3:0]        r_mem_byte_en, w_be;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off, w_size;
    logic              r_mem_read, r_mem_write, r_timeout_err;
    logic              w_wr_req, w_rd_req, w_req, w_mis, w_issue, w_done, w_tmo;
    // A set store-enable suppresses the load even when the store size is undefined.
    assign w_wr_req = i_mem_stage_write[2] && i_mem_stage_write[1:0] != 2'b11;
    assign w_rd_req = !i_mem_stage_write[2] && i_mem_stage_read[3] &&
                      (i_mem_stage_read[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_req    = w_wr_req || w_rd_req;
    assign w_size   = i_mem_stage_write[2] ? i_mem_stage_write[1:0] : i_mem_stage_read[1:0];
    assign w_mis    = (w_size == 2'b01 && i_address[0]) || (w_size == 2'b10 && |i_address[1:0]);
    assign w_issue  = r_state == S_IDLE && w_req && !w_mis;
    assign w_done   = r_state == S_WAIT && !i_mem_busywait;
    assign w_tmo    = r_state == S_WAIT && i_mem_busywait && TIMEOUT != 0 &&
                      r_cnt + 32'd1 == 32'(TIMEOUT);
    always_comb begin
        w_be    = i_mem_stage_write[1:0] == 2'b00 ? 4'b0001 << i_address[1:0] :
                  i_mem_stage_write[1:0] == 2'b01 ? (i_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = i_mem_stage_write[1:0] == 2'b00 ? {4{i_write_data[7:0]}} :
                  i_mem_stage_write[1:0] == 2'b01 ? {2{i_write_data[15:0]}} : i_write_data;
        w_lane  = i_mem_readdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = w_issue ? S_WAIT :
                 (w_done || w_tmo) ? S_DONE :
                 r_state == S_DONE ? S_IDLE : r_state;
    end
    always_comb begin
        o_busywait      = i_rst_n && (w_issue || r_state == S_WAIT);
        o_misaligned    = i_rst_n && r_state == S_IDLE && w_req && w_mis;
        o_read_data     = r_read_data;
        o_timeout_err   = r_timeout_err;
        o_mem_read      = r_mem_read;
        o_mem_write     = r_mem_write;
        o_mem_address   = r_mem_address;
        o_mem_writedata = r_mem_writedata;
        o_mem_byte_en   = r_mem_byte_en;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_read_data     <= '0;
            r_mem_writedata <= '0;
            r_mem_address   <= '0;
            r_mem_byte_en   <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_cnt           <= '0;
            r_funct3        <= '0;
            r_off           <= '0;
        end else if (w_issue) begin
            r_mem_read      <= w_rd_req;
            r_mem_write     <= w_wr_req;
            r_mem_address   <= i_address[MEM_AW+1:2];
            r_mem_writedata <= w_wdata;
            r_mem_byte_en   <= w_wr_req ? w_be : 4'b0000;
            r_funct3        <= i_mem_stage_read[2:0];
            r_off           <= i_address[1:0];
            r_cnt           <= '0;
        end else if (w_done) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) r_read_data <= w_ext;
        end else if (w_tmo) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_timeout_err <= 1'b1;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pr_ex_mem_data_port.sv
// tb_pr_ex_mem_data_port: directed transactions against a transaction-level
// model, checked every cycle, plus literal expectations from hand calculation.
module tb_pr_ex_mem_data_port;
    localparam int TMO = 4;
    logic        clk = 0, rst_n = 0;
    logic [3:0]  rd = '0;
    logic [2:0]  wr = '0;
    logic [31:0] addr = '0, wdata = '0, mrdata = '0;
    logic [31:0] o_read_data, o_mem_writedata;
    logic [29:0] o_mem_address;
    logic [3:0]  o_mem_byte_en;
    logic        o_busywait, o_misaligned, o_timeout_err, o_mem_read, o_mem_write, mem_busy;
    int          mem_cnt = 0, mem_lat = 0, checks = 0, errors = 0, busy_cycles = 0;
    logic        chk_en = 0;
    logic        exp_busy = 0, exp_mis = 0, exp_rd = 0, exp_wr = 0, exp_err = 0;
    logic [31:0] exp_data = '0, exp_maddr = '0, exp_mwd = '0;
    logic [3:0]  exp_be = '0;

    always #5 clk = ~clk;

    pr_ex_mem_data_port #(.TIMEOUT(TMO), .MEM_AW(30)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_stage_read(rd), .i_mem_stage_write(wr),
        .i_address(addr), .i_write_data(wdata),
        .o_read_data(o_read_data), .o_busywait(o_busywait),
        .o_misaligned(o_misaligned), .o_timeout_err(o_timeout_err),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_address(o_mem_address), .o_mem_writedata(o_mem_writedata),
        .o_mem_byte_en(o_mem_byte_en), .i_mem_readdata(mrdata),
        .i_mem_busywait(mem_busy)
    );

    // Memory stays busy for the first mem_lat cycles a request is held.
    assign mem_busy = mem_cnt <= mem_lat;
    always @(posedge clk) begin
        #1;
        mem_cnt = (o_mem_read || o_mem_write) ? mem_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] off);
        logic [31:0] l;
        l = w >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(l[7:0]));
            3'b001:  return 32'($signed(l[15:0]));
            3'b100:  return 32'(l[7:0]);
            3'b101:  return 32'(l[15:0]);
            default: return l;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
        int nbytes;
        nbytes = 1 << sz;
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) if (chk_en) begin
        if (o_busywait) busy_cycles++;
        chk("busywait", 32'(o_busywait), 32'(exp_busy));
        chk("misaligned", 32'(o_misaligned), 32'(exp_mis));
        chk("mem_read", 32'(o_mem_read), 32'(exp_rd));
        chk("mem_write", 32'(o_mem_write), 32'(exp_wr));
        chk("read_data", o_read_data, exp_data);
        chk("timeout_err", 32'(o_timeout_err), 32'(exp_err));
        if (exp_rd || exp_wr) begin
            chk("mem_address", 32'(o_mem_address), exp_maddr);
            chk("byte_en", 32'(o_byte_en_w()), 32'(exp_be));
            if (exp_wr) chk("writedata", o_mem_writedata, exp_mwd);
        end
    end

    function automatic logic [3:0] o_byte_en_w();
        return o_mem_byte_en;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic access(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] m, input int lat);
        logic st, ld, req, mis, tmo;
        logic [1:0] sz;
        int nw;
        rd = r; wr = w; addr = a; wdata = d; mrdata = m; mem_lat = lat;
        st  = w[2] && w[1:0] != 2'b11;
        ld  = !w[2] && r[3] && (r[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req = st || ld;
        sz  = w[2] ? w[1:0] : r[1:0];
        mis = req && (a % (32'd1 << sz) != 0);
        exp_rd = 0; exp_wr = 0;
        if (!req || mis) begin
            exp_busy = 0; exp_mis = mis;
            @(posedge clk); #1;
            exp_mis = 0;
            return;
        end
        tmo = (TMO != 0) && (lat + 1 > TMO);
        nw  = tmo ? TMO : lat + 1;
        exp_busy = 1; exp_mis = 0;
        exp_maddr = a >> 2;
        exp_be    = ld ? 4'b0000 : f_be(sz, a[1:0]);
        exp_mwd   = f_wd(sz, d);
        @(posedge clk); #1;
        exp_rd = ld; exp_wr = st;
        repeat (nw) @(posedge clk);
        #1;
        exp_busy = 0; exp_rd = 0; exp_wr = 0;
        if (tmo) exp_err = 1;
        else if (ld) exp_data = f_load(r[2:0], m, a[1:0]);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rd = '0; wr = '0;
        exp_busy = 0; exp_mis = 0; exp_rd = 0; exp_wr = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_read_data", o_read_data, 32'h0);
        chk("rst_busywait", 32'(o_busywait), 32'h0);
        chk("rst_mem_read", 32'(o_mem_read), 32'h0);
        chk("rst_mem_write", 32'(o_mem_write), 32'h0);
        chk("rst_mem_address", 32'(o_mem_address), 32'h0);
        chk("rst_byte_en", 32'(o_mem_byte_en), 32'h0);
        chk("rst_writedata", o_mem_writedata, 32'h0);
        chk("rst_timeout_err", 32'(o_timeout_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        chk_en = 1;
        idle();
        busy_cycles = 0;
        access(4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        chk("lit_lw_data", o_read_data, 32'hDEADBEEF);
        chk("lit_lw_addr", 32'(o_mem_address), 32'h40);
        chk("lit_lw_stall", busy_cycles, 3);
        access(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
        chk("lit_lb", o_read_data, 32'hFFFFFF80);
        access(4'b1100, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
        chk("lit_lbu", o_read_data, 32'h00000080);
        idle();
        access(4'b1001, 3'b000, 32'h102, 32'h0, 32'h9ABC1234, 2);
        chk("lit_lh", o_read_data, 32'hFFFF9ABC);
        access(4'b1101, 3'b000, 32'h102, 32'h0, 32'h9ABC1234, 0);
        chk("lit_lhu", o_read_data, 32'h00009ABC);
        access(4'b0000, 3'b101, 32'h102, 32'h0000A5A5, 32'h0, 1);
        chk("lit_sh_be", 32'(o_mem_byte_en), 32'hC);
        chk("lit_sh_wd", o_mem_writedata, 32'hA5A5A5A5);
        idle();
        access(4'b0000, 3'b100, 32'h101, 32'h000000EE, 32'h0, 0);
        chk("lit_sb_be", 32'(o_mem_byte_en), 32'h2);
        chk("lit_sb_wd", o_mem_writedata, 32'hEEEEEEEE);
        access(4'b0000, 3'b110, 32'h104, 32'h12345678, 32'h0, 0);
        chk("lit_sw_be", 32'(o_mem_byte_en), 32'hF);
        access(4'b1010, 3'b110, 32'h108, 32'hCAFEF00D, 32'h11111111, 1);
        chk("lit_store_wins", o_read_data, 32'h00009ABC);
        idle();
        access(4'b1010, 3'b000, 32'h102, 32'h0, 32'h55555555, 0);
        chk("lit_mis_data", o_read_data, 32'h00009ABC);
        access(4'b0000, 3'b101, 32'h101, 32'h1234, 32'h0, 0);
        access(4'b1011, 3'b000, 32'h100, 32'h0, 32'h0, 0);
        access(4'b0000, 3'b111, 32'h100, 32'h0, 32'h0, 0);
        idle();
        access(4'b1010, 3'b000, 32'h10C, 32'h0, 32'h0BADF00D, TMO - 1);
        chk("lit_last_chance", o_read_data, 32'h0BADF00D);
        idle();
        access(4'b1010, 3'b000, 32'h110, 32'h0, 32'h77777777, 1000);
        chk("lit_tmo_err", 32'(o_timeout_err), 32'h1);
        chk("lit_tmo_data", o_read_data, 32'h0BADF00D);
        idle();
        chk_en = 0;
        rd = 4'b1010; addr = 32'h200; mem_lat = 5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_read", 32'(o_mem_read), 32'h1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_read", 32'(o_mem_read), 32'h0);
        chk("rst_async_busy", 32'(o_busywait), 32'h0);
        chk("rst_async_err", 32'(o_timeout_err), 32'h0);
        chk("rst_async_data", o_read_data, 32'h0);
        rd = '0;
        @(posedge clk); #1;
        rst_n = 1;
        exp_data = 0; exp_err = 0;
        chk_en = 1;
        idle();
        access(4'b1100, 3'b000, 32'h0, 32'h0, 32'h000000FF, 0);
        chk("lit_post_rst", o_read_data, 32'h000000FF);
        idle();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pr_ex_mem_data_port.md
Name: pr_ex_mem_data_port

Overview:
- Responder at the far end of the memory-control fields carried by the ID/EX → EX/MEM pipeline path.
- Takes the MEM-stage read/write codes, address and store data, and drives a word-wide, multi-cycle data memory.
- Performs byte-lane steering on stores and lane extraction plus sign/zero extension on loads.
- Drives BUSYWAIT to stall every pipeline register until the access completes.

Parameters:
- TIMEOUT, 255, maximum WAIT cycles before the access is aborted; 0 disables the watchdog.
- MEM_AW, 30, memory word-address width; MEM_ADDRESS = ADDRESS[MEM_AW+1:2].

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- MEM_STAGE_READ  in  4  [3]=load enable, [2:0]=funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- MEM_STAGE_WRITE  in  3  [2]=store enable, [1:0]: 00 SB, 01 SH, 10 SW
- ADDRESS  in  32  byte address from the ALU result
- WRITE_DATA  in  32  store data (rs2)
- READ_DATA  out  32  extended load result
- BUSYWAIT  out  1  pipeline stall request
- MISALIGNED  out  1  misaligned-access flag (combinational)
- TIMEOUT_ERR  out  1  sticky watchdog error
- MEM_READ  out  1  memory read request (registered)
- MEM_WRITE  out  1  memory write request (registered)
- MEM_ADDRESS  out  MEM_AW  word address (registered)
- MEM_WRITEDATA  out  32  lane-steered store data (registered)
- MEM_BYTE_EN  out  4  store byte enables (registered)
- MEM_READDATA  in  32  memory read word
- MEM_BUSYWAIT  in  1  memory busy; low at a sampled edge with a request high = access complete

Behaviour:
- Reset (RESET low, asynchronous): all outputs 0; state IDLE; watchdog counter 0. Reset mid-access drops MEM_READ/MEM_WRITE immediately; no completion is reported.
- Request detection: a request is present when MEM_STAGE_WRITE[2] or MEM_STAGE_READ[3] is 1.
  - If both are set, the store wins and the load is ignored.
  - Undefined funct3 or write size 11 is treated as no request.
- Misalignment:
  - Halfword access with ADDRESS[0]=1 is misaligned.
  - Word access with ADDRESS[1:0]≠0 is misaligned.
  - MISALIGNED = IDLE && request && misaligned. No memory access is issued, BUSYWAIT stays 0, READ_DATA is unchanged.
- States:
  - IDLE:
    - Aligned request → register MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTE_EN, the load type and ADDRESS[1:0].
    - Set MEM_READ or MEM_WRITE; go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - At an edge where MEM_BUSYWAIT=0:
      - Load → capture the extended MEM_READDATA into READ_DATA.
      - Clear MEM_READ/MEM_WRITE; go to DONE.
    - Counter reaches TIMEOUT (when TIMEOUT≠0) before completion:
      - Clear the request, set TIMEOUT_ERR, leave READ_DATA unchanged, go to DONE.
      - TIMEOUT_ERR clears only on reset.
  - DONE: one cycle; no issue even though the request is still present; go to IDLE.
- BUSYWAIT = (IDLE && aligned request) || WAIT. It is 0 in DONE, so the pipeline advances at the edge ending DONE.
- Minimum stall: request visible in cycle 0; BUSYWAIT is high in cycles 0 and 1 and low in cycle 2 (DONE).
- Store steering:
  - SB: MEM_BYTE_EN = 0001 << ADDRESS[1:0]; MEM_WRITEDATA = {4{WRITE_DATA[7:0]}}.
  - SH: MEM_BYTE_EN = ADDRESS[1] ? 1100 : 0011; MEM_WRITEDATA = {2{WRITE_DATA[15:0]}}.
  - SW: MEM_BYTE_EN = 1111; MEM_WRITEDATA = WRITE_DATA.
- Loads:
  - MEM_BYTE_EN = 0000.
  - Lane = MEM_READDATA >> (8 × ADDRESS[1:0]), using the registered offset.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- READ_DATA holds its value until the next completed load.

Test Plan:
- Aligned LW, ADDRESS=0x100, MEM_READDATA=0xDEADBEEF, memory busy 2 cycles:
  - MEM_READ=1, MEM_ADDRESS=0x40.
  - BUSYWAIT high for 3 cycles, then low for 1.
  - READ_DATA=0xDEADBEEF.
- LB/LBU at ADDRESS=0x103, word 0x80112233: LB → 0xFFFFFF80; LBU → 0x00000080.
- LH at 0x102, word 0x9ABC1234 → 0xFFFF9ABC; SH at 0x102, WRITE_DATA=0x0000A5A5 → BYTE_EN=1100, WRITEDATA=0xA5A5A5A5.
- SB at 0x101, WRITE_DATA=0x000000EE → BYTE_EN=0010, WRITEDATA=0xEEEEEEEE; back-to-back second store issues in the cycle after DONE.
- Misaligned case, LW at 0x102:
  - MISALIGNED=1, BUSYWAIT=0, MEM_READ stays 0, READ_DATA unchanged.
- Error and reset cases:
  - TIMEOUT=4 with MEM_BUSYWAIT held at 1 → TIMEOUT_ERR=1 after 4 WAIT cycles, request dropped.
  - RESET low mid-WAIT → MEM_READ=0, BUSYWAIT=0 without waiting for a clock edge.
